// File: rtl/axil_regfile_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite register bank.
package axil_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         NUM_LANES   = 4;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/axil_regfile_wmerge.sv
// Byte-strobe merge: lanes with a set strobe take the new data, others keep the old word.
module axil_regfile_wmerge
    import axil_regfile_pkg::*;
(
    input  logic [8*NUM_LANES-1:0] old_word,
    input  logic [8*NUM_LANES-1:0] wdata,
    input  logic [NUM_LANES-1:0]   wstrb,
    output logic [8*NUM_LANES-1:0] new_word
);

    // Per-lane select between retained and incoming byte
    always_comb begin
        new_word = old_word;
        for (int b = 0; b < NUM_LANES; b++) begin
            if (wstrb[b]) begin
                new_word[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                new_word[8*b +: 8] = old_word[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers with per-register new-value flags.
// Build option: define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_regfile
    import axil_regfile_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    parameter  int ADDR_W   = 32,
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_W-1:0]        ARADDR,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_valid,
    input  logic [NUM_REGS-1:0]      reg_ack
);

`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    wstate_e               wstate_q, wstate_d;
    rstate_e               rstate_q, rstate_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [32*NUM_REGS-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]   reg_valid_q, reg_valid_d;

    logic                  aw_hs_s, w_hs_s, b_hs_s, ar_hs_s;
    logic                  aw_have_s, w_have_s, commit_s;
    logic [ADDR_W-1:0]     cm_addr_s;
    logic [31:0]           cm_data_s, old_word_s, merged_s, r_word_s;
    logic [3:0]            cm_strb_s;
    logic                  w_in_range_s, r_in_range_s;
    logic [IDX_W-1:0]      w_idx_s, r_idx_s;
    logic [NUM_REGS-1:0]   set_s;
    logic                  unused_s;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2] < (ADDR_W-2)'(NUM_REGS);
    endfunction

    assign aw_hs_s   = AWVALID && awready_q;
    assign w_hs_s    = WVALID && wready_q;
    assign b_hs_s    = BREADY && bvalid_q;
    assign ar_hs_s   = ARVALID && arready_q;
    assign aw_have_s = aw_held_q || aw_hs_s;
    assign w_have_s  = w_held_q || w_hs_s;
    assign commit_s  = (wstate_q == W_IDLE) && aw_have_s && w_have_s;

    // A channel captured in an earlier cycle is used from its latch, otherwise straight from the bus
    assign cm_addr_s    = aw_held_q ? awaddr_q : AWADDR;
    assign cm_data_s    = w_held_q ? wdata_q : WDATA;
    assign cm_strb_s    = w_held_q ? wstrb_q : WSTRB;
    assign w_in_range_s = addr_in_range(cm_addr_s);
    assign w_idx_s      = w_in_range_s ? cm_addr_s[IDX_W+1:2] : '0;
    assign old_word_s   = regs_q[{w_idx_s, 5'd0} +: 32];
    assign r_in_range_s = addr_in_range(ARADDR);
    assign r_idx_s      = r_in_range_s ? ARADDR[IDX_W+1:2] : '0;
    assign r_word_s     = regs_q[{r_idx_s, 5'd0} +: 32];
    assign unused_s     = ^{AWPROT, ARPROT, cm_addr_s[1:0], ARADDR[1:0]};

    axil_regfile_wmerge u_wmerge (
        .old_word (old_word_s),
        .wdata    (cm_data_s),
        .wstrb    (cm_strb_s),
        .new_word (merged_s)
    );

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q    <= W_IDLE;
            rstate_q    <= R_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= RESP_OKAY;
            regs_q      <= '0;
            reg_valid_q <= '0;
        end else begin
            wstate_q    <= wstate_d;
            rstate_q    <= rstate_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            regs_q      <= regs_d;
            reg_valid_q <= reg_valid_d;
        end
    end

    // Write FSM next state
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (commit_s) wstate_d = W_RESP;
                else          wstate_d = W_IDLE;
            end
            W_RESP: begin
                if (b_hs_s) wstate_d = W_IDLE;
                else        wstate_d = W_RESP;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // AW/W channel latches, cleared once the write commits
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (commit_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            aw_held_d = aw_have_s;
            w_held_d  = w_have_s;
        end
        if (aw_hs_s) awaddr_d = AWADDR;
        else         awaddr_d = awaddr_q;
        if (w_hs_s) begin
            wdata_d = WDATA;
            wstrb_d = WSTRB;
        end else begin
            wdata_d = wdata_q;
            wstrb_d = wstrb_q;
        end
    end

    // Write FSM outputs
    always_comb begin
        awready_d = (wstate_d == W_IDLE) && !aw_held_d;
        wready_d  = (wstate_d == W_IDLE) && !w_held_d;
        bvalid_d  = (wstate_d == W_RESP);
        bresp_d   = bresp_q;
        if (commit_s) bresp_d = w_in_range_s ? RESP_OKAY : OOR_RESP;
        else          bresp_d = bresp_q;
    end

    // Register bank and new-value flags; a commit beats a same-cycle acknowledge
    always_comb begin
        regs_d = regs_q;
        set_s  = '0;
        if (commit_s && w_in_range_s) begin
            regs_d[{w_idx_s, 5'd0} +: 32] = merged_s;
            set_s[w_idx_s]                = 1'b1;
        end else begin
            regs_d = regs_q;
            set_s  = '0;
        end
        reg_valid_d = (reg_valid_q & ~reg_ack) | set_s;
    end

    // Read FSM next state
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_hs_s) rstate_d = R_DATA;
                else         rstate_d = R_IDLE;
            end
            R_DATA: begin
                if (RREADY) rstate_d = R_IDLE;
                else        rstate_d = R_DATA;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read FSM outputs; data sampled from the bank before any same-edge write
    always_comb begin
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (ar_hs_s) begin
            rdata_d = r_in_range_s ? r_word_s : 32'd0;
            rresp_d = r_in_range_s ? RESP_OKAY : OOR_RESP;
        end else begin
            rdata_d = rdata_q;
            rresp_d = rresp_q;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign ARREADY   = arready_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign reg_q     = regs_q;
    assign reg_valid = reg_valid_q;

endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile: directed cases then randomized traffic against a register-array model.
module tb_axil_regfile;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 32;
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic                   ACLK, ARESETN;
    logic [ADDR_W-1:0]      AWADDR, ARADDR;
    logic [2:0]             AWPROT, ARPROT;
    logic                   AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic                   ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]            WDATA, RDATA;
    logic [3:0]             WSTRB;
    logic [1:0]             BRESP, RRESP;
    logic [32*NUM_REGS-1:0] reg_q;
    logic [NUM_REGS-1:0]    reg_valid, reg_ack;

    axil_regfile #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .reg_valid(reg_valid), .reg_ack(reg_ack)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int compared = 0;
    int mismatched = 0;
    logic [31:0]         m_regs [NUM_REGS];
    logic [NUM_REGS-1:0] m_valid;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32*NUM_REGS-1:0] m_flat();
        logic [32*NUM_REGS-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'd0;
        m_valid = '0;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        logic [31:0] mask;
        int idx;
        idx  = int'(addr >> 2);
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx < NUM_REGS) begin
            m_regs[idx]  = (m_regs[idx] & ~mask) | (data & mask);
            m_valid[idx] = 1'b1;
            resp = 2'b00;
        end else begin
            resp = OOR;
        end
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int b_delay, input logic [NUM_REGS-1:0] ack);
        logic aw_done, w_done, aw_now, w_now;
        logic [1:0] exp_resp;
        int cyc, aw_start, w_start;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWPROT = 3'($urandom);
        while (!(aw_done && w_done) && cyc < 20) begin
            AWVALID = !aw_done && (cyc >= aw_start);
            WVALID  = !w_done && (cyc >= w_start);
            reg_ack = (cyc == 0) ? ack : '0;
            aw_now  = AWVALID && AWREADY;
            w_now   = WVALID && WREADY;
            @(negedge ACLK);
            aw_done = aw_done | aw_now;
            w_done  = w_done | w_now;
            cyc++;
        end
        AWVALID = 1'b0; WVALID = 1'b0; reg_ack = '0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        if (!(aw_done && w_done)) return;
        m_valid = m_valid & ~ack;
        model_write(addr, data, strb, exp_resp);
        chk("wr_bvalid_rise", BVALID, 1'b1);
        chk("wr_bresp", BRESP, exp_resp);
        chk("wr_reg_q", reg_q, m_flat());
        chk("wr_reg_valid", reg_valid, m_valid);
        chk("wr_ready_low_in_resp", {AWREADY, WREADY}, 2'b00);
        for (int i = 0; i < b_delay; i++) begin
            @(negedge ACLK);
            chk("wr_bvalid_hold", {BVALID, BRESP}, {1'b1, exp_resp});
            chk("wr_blocked", {AWREADY, WREADY}, 2'b00);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("wr_b_done", {BVALID, AWREADY, WREADY}, 3'b011);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_delay);
        logic ar_now, ar_done;
        logic [31:0] exp_data;
        logic [1:0] exp_resp;
        int cyc, idx;
        ar_done = 1'b0; cyc = 0;
        ARADDR = addr; ARPROT = 3'($urandom); ARVALID = 1'b1;
        while (!ar_done && cyc < 20) begin
            ar_now = ARVALID && ARREADY;
            @(negedge ACLK);
            ar_done = ar_now;
            cyc++;
        end
        ARVALID = 1'b0;
        chk("rd_handshake", ar_done, 1'b1);
        if (!ar_done) return;
        idx      = int'(addr >> 2);
        exp_data = (idx < NUM_REGS) ? m_regs[idx] : 32'd0;
        exp_resp = (idx < NUM_REGS) ? 2'b00 : OOR;
        chk("rd_rvalid_rise", {RVALID, ARREADY}, 2'b10);
        chk("rd_rdata", RDATA, exp_data);
        chk("rd_rresp", RRESP, exp_resp);
        for (int i = 0; i < r_delay; i++) begin
            @(negedge ACLK);
            chk("rd_hold", {RVALID, RDATA, RRESP}, {1'b1, exp_data, exp_resp});
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        RREADY = 1'b0;
        chk("rd_done", {RVALID, ARREADY}, 2'b01);
    endtask

    logic [31:0] r_addr, r_data, old_val;
    logic [1:0]  dummy_resp;
    logic [NUM_REGS-1:0] r_ack;
    int op;

    initial begin
        ARESETN = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARVALID = 1'b0; RREADY = 1'b0; reg_ack = '0;
        AWADDR = 32'd0; ARADDR = 32'd0; WDATA = 32'd0; WSTRB = 4'd0;
        AWPROT = 3'd0; ARPROT = 3'd0;
        model_clear();

        // Reset state
        repeat (2) @(negedge ACLK);
        chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("rst_valids", {BVALID, RVALID}, 2'b00);
        chk("rst_data_resp", {RDATA, BRESP, RRESP}, 36'd0);
        chk("rst_regs", {reg_q, reg_valid}, '0);
        ARESETN = 1'b1;
        #1 chk("rel_readys_low", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("rel_readys_high", {AWREADY, WREADY, ARREADY}, 3'b111);

        // AW and W together, full strobe
        do_write(32'h0000_0004, 32'hDEADBEEF, 4'hF, 0, 0, '0);
        chk("t1_reg1", reg_q[63:32], 32'hDEADBEEF);
        chk("t1_valid", reg_valid, 8'h02);

        // W two cycles ahead of AW, partial strobe, BREADY held off 3 cycles
        do_write(32'h0000_0008, 32'h11223344, 4'h5, 2, 3, '0);
        chk("t2_reg2", reg_q[95:64], 32'h00220044);

        // Read back with delayed RREADY
        do_read(32'h0000_0004, 2);

        // Out-of-range write and read
        do_write(32'(4 * NUM_REGS), 32'hCAFEF00D, 4'hF, 0, 0, '0);
        do_read(32'(4 * NUM_REGS), 1);

        // Zero strobe still flags the register; AW before W
        do_write(32'h0000_000C, 32'hFFFF_FFFF, 4'h0, -1, 0, '0);

        // Acknowledge coinciding with a commit loses; a lone acknowledge clears
        do_write(32'h0000_0004, 32'h0BAD_F00D, 4'h3, 0, 0, 8'h02);
        chk("ack_vs_set", reg_valid[1], 1'b1);
        reg_ack = 8'h02;
        @(negedge ACLK);
        reg_ack = '0;
        m_valid[1] = 1'b0;
        chk("ack_clear", reg_valid, m_valid);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            op     = int'($urandom_range(0, 2));
            r_addr = (32'($urandom_range(0, NUM_REGS + 1)) << 2) | 32'($urandom_range(0, 3));
            r_ack  = (n % 2 == 0) ? NUM_REGS'($urandom) : '0;
            case (op)
                0, 1:    do_write(r_addr, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
                                  int'($urandom_range(0, 2)), r_ack);
                default: do_read(r_addr, int'($urandom_range(0, 2)));
            endcase
            if (n % 3 == 0) begin
                reg_ack = NUM_REGS'($urandom);
                m_valid = m_valid & ~reg_ack;
                @(negedge ACLK);
                reg_ack = '0;
                chk("rand_ack", reg_valid, m_valid);
            end
        end

        // Same-cycle read and write to one register: read sees the old value
        r_data  = $urandom;
        old_val = m_regs[2];
        ARADDR = 32'h8; ARVALID = 1'b1;
        AWADDR = 32'h8; WDATA = r_data; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        model_write(32'h8, r_data, 4'hF, dummy_resp);
        chk("rw_both_valid", {BVALID, RVALID}, 2'b11);
        chk("rw_prewrite_rdata", RDATA, old_val);
        chk("rw_reg_q", reg_q, m_flat());

        // Asynchronous reset with both responses pending
        #2 ARESETN = 1'b0;
        #1;
        chk("arst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'd0);
        chk("arst_data", {RDATA, BRESP, RRESP}, 36'd0);
        chk("arst_regs", {reg_q, reg_valid}, '0);
        model_clear();
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("arst_rel_readys", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);

        do_write(32'h0000_001C, 32'h5A5A_A5A5, 4'hF, 1, 1, '0);
        do_read(32'h0000_001C, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axil_regfile.md
# axil_regfile

AXI4-Lite slave that exposes a parametrised bank of NUM_REGS control registers to the processing system, replacing the single-register, write-only control slave. It implements full write and read channels with proper VALID/READY handshakes, per-byte write strobes, and a per-register "new value" flag with consumer acknowledge. It sits between the AXI interconnect and the fabric datapath blocks that consume control words.

## Interface
- NUM_REGS, 8, number of 32-bit registers (1..256)
- ADDR_W, 32, AXI address width
- IDX_W, $clog2(NUM_REGS) (min 1), register index width (derived, not overridden)
- ACLK  in  1  single clock; all logic on rising edge
- ARESETN  in  1  reset, asynchronous assert, active-low
- AWADDR in ADDR_W; AWPROT in 3; AWVALID in 1; AWREADY out 1  write address channel
- WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1  write data channel
- BRESP out 2; BVALID out 1; BREADY in 1  write response channel
- ARADDR in ADDR_W; ARPROT in 3; ARVALID in 1; ARREADY out 1  read address channel
- RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1  read data channel
- reg_q  out  32*NUM_REGS  flattened register contents; register i at [32*i +: 32]
- reg_valid  out  NUM_REGS  bit i set when register i is written, until acknowledged
- reg_ack  in  NUM_REGS  consumer pulse clearing reg_valid[i]

## Operation
- Decode: word index = addr >> 2; addr[1:0] ignored; index >= NUM_REGS is out of range. AWPROT/ARPROT ignored.
- Write FSM states: W_IDLE, W_RESP.
  - In W_IDLE, AWREADY=1 until AW captured and WREADY=1 until W captured. Each channel is latched independently in either order or in the same cycle.
  - When both are held, commit the write and go to W_RESP with BVALID=1.
  - Commit: for each b in 0..3 with WSTRB[b]=1, byte b of the target register takes WDATA[8b+7:8b]. Zero strobes leave data unchanged, but reg_valid is still set.
  - W_RESP holds BVALID and BRESP until BREADY, then returns to W_IDLE. AWREADY=WREADY=0 in W_RESP.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On the AR handshake, capture RDATA from the addressed register and go to R_DATA with RVALID=1.
  - R_DATA: ARREADY=0. RDATA/RRESP stay stable until RREADY, then return to R_IDLE.
- Out-of-range access: the write is dropped (no register or reg_valid change). The read returns RDATA=0. Response code per Configuration.
- reg_valid[i]: set on commit to register i, cleared by reg_ack[i]. If set and clear happen in the same cycle, set wins.
- Read and write FSMs are independent. A read and a write commit to the same register in the same cycle return the pre-write value.
- Reset (ARESETN low, any time, including mid-transaction):
  - All READYs, BVALID and RVALID go to 0; RDATA=0, BRESP=RRESP=2'b00.
  - reg_q=0, reg_valid=0; FSMs go to W_IDLE/R_IDLE; in-flight transactions are discarded.
  - AWREADY/WREADY/ARREADY rise on the first edge after release.

## Timing
- All outputs are registered.
- Write: commit and BVALID rise on the edge after the later of the AW/W handshakes. The earliest next AW/W handshake is the cycle after the B handshake.
- Read: RVALID rises on the edge after the AR handshake. Throughput is one read per 2 cycles with RREADY tied high.
- reg_q and reg_valid update on the same edge that BVALID rises. reg_valid clears on the edge after reg_ack is sampled high.

## Configuration
- AXIL_REGFILE_SLVERR_EN defined: out-of-range write or read returns BRESP/RRESP=2'b10 (SLVERR).
- Undefined: out-of-range accesses return 2'b00 (OKAY).
- Data and register behaviour are identical in both builds.

## Structure
- Package axil_regfile_pkg holds:
  - response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - write and read FSM state typedefs
  - the byte-lane count constant (4)
- One sub-module, axil_regfile_wmerge: combinational strobe merge (old word, WDATA, WSTRB -> new word), instantiated once on the committed target.

## Test plan
- AW and W in the same cycle, addr 0x04, WDATA 0xDEADBEEF, WSTRB 0xF -> BVALID the next cycle, BRESP 0; reg_q[63:32]=0xDEADBEEF; reg_valid=0x02.
- W two cycles before AW, addr 0x08, WSTRB 0x5, WDATA 0x11223344 on a register holding 0 -> register 2 = 0x00220044; BREADY held low for 3 cycles keeps BVALID high and blocks the next write.
- Read addr 0x04 after the first test, RREADY delayed 2 cycles -> RVALID one cycle after the AR handshake; RDATA 0xDEADBEEF held stable until RREADY.
- Write addr 4*NUM_REGS -> no reg_q/reg_valid change; BRESP 2'b10 with AXIL_REGFILE_SLVERR_EN, 2'b00 without. A read to the same address gives RDATA 0 and the matching RRESP.
- reg_ack[1] pulsed in the same cycle as a commit to register 1 -> reg_valid[1] stays 1. A later reg_ack[1] alone clears it.
- ARESETN dropped while BVALID=1 and RVALID=1 -> all outputs and registers go to 0 immediately. READYs return 1 on the first edge after release.
